// File: rtl/csr_arbiter.sv
// csr_arbiter: two-requester round-robin front end for a simple CSR port.
// One request is in flight at a time. Writes hold csr_we_o for WR_HOLD cycles
// and then keep address/data stable for WR_GAP more cycles. Reads hold
// csr_re_o for RD_WAIT cycles and capture csr_rdata_i on the last of them.
// Each transaction completes with a one-cycle done pulse to its requester.
module csr_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int WR_HOLD    = 4,
    parameter int WR_GAP     = 4,
    parameter int RD_WAIT    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req0_valid_i,
    input  logic                  req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    output logic                  req0_ready_o,
    output logic                  req0_done_o,
    output logic [DATA_WIDTH-1:0] req0_rdata_o,

    input  logic                  req1_valid_i,
    input  logic                  req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    output logic                  req1_ready_o,
    output logic                  req1_done_o,
    output logic [DATA_WIDTH-1:0] req1_rdata_o,

    output logic [ADDR_WIDTH-1:0] csr_addr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  csr_we_o,
    output logic                  csr_re_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i,

    output logic                  busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_ACT = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_ACT = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] WR_HOLD_LD = 4'(WR_HOLD - 1);
    localparam logic [3:0] WR_GAP_LD  = 4'(WR_GAP - 1);
    localparam logic [3:0] RD_WAIT_LD = 4'(RD_WAIT - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  idx_q;       // requester owning the transaction in flight
    logic                  last_q;      // requester served most recently
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Per-requester views of the request ports, so the selection logic can index them.
    logic [1:0]            valid_vec;
    logic [1:0]            we_vec;
    logic [ADDR_WIDTH-1:0] addr_vec  [2];
    logic [DATA_WIDTH-1:0] wdata_vec [2];
    logic [1:0]            gnt_vec;
    logic [1:0]            ready_vec;
    logic [1:0]            done_vec;

    logic                  accept;
    logic                  acc_idx;
    logic                  acc_we;
    logic                  rd_capture;

    assign valid_vec    = {req1_valid_i, req0_valid_i};
    assign we_vec       = {req1_we_i, req0_we_i};
    assign addr_vec[0]  = req0_addr_i;
    assign addr_vec[1]  = req1_addr_i;
    assign wdata_vec[0] = req0_wdata_i;
    assign wdata_vec[1] = req1_wdata_i;

    // Round-robin: a lone valid always wins; on a tie the requester not served last wins.
    assign gnt_vec[0] = valid_vec[0] & (~valid_vec[1] | last_q);
    assign gnt_vec[1] = valid_vec[1] & (~valid_vec[0] | ~last_q);

    // Ready is only offered in IDLE, so acceptance is simply IDLE plus any grant.
    assign accept  = (state_q == S_IDLE) && (gnt_vec != 2'b00);
    assign acc_idx = gnt_vec[1];
    assign acc_we  = we_vec[acc_idx];

    // Read data is sampled at the edge that ends the final RD_ACT cycle.
    assign rd_capture = (state_q == S_RD_ACT) && (cnt_q == 4'd0);

    // State and counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_we) begin
                        state_d = S_WR_ACT;
                        cnt_d   = WR_HOLD_LD;
                    end else begin
                        state_d = S_RD_ACT;
                        cnt_d   = RD_WAIT_LD;
                    end
                end
            end
            S_WR_ACT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WR_GAP;
                    cnt_d   = WR_GAP_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD_ACT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Latch the accepted request; address/data stay put until the next acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= 1'b0;
            last_q  <= 1'b1;
        end else if (accept) begin
            addr_q  <= addr_vec[acc_idx];
            wdata_q <= wdata_vec[acc_idx];
            idx_q   <= acc_idx;
            last_q  <= acc_idx;
        end
    end

    // Per-requester read-data holding registers; only the owner's read updates them.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [DATA_WIDTH-1:0] rdata_q;

            // Capture read data for this requester at the end of its read.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rdata_q <= '0;
                end else if (rd_capture && (idx_q == 1'(gi))) begin
                    rdata_q <= csr_rdata_i;
                end
            end
        end
    endgenerate

    // Outputs decoded from the current state.
    always_comb begin
        csr_we_o  = 1'b0;
        csr_re_o  = 1'b0;
        busy_o    = 1'b1;
        ready_vec = 2'b00;
        done_vec  = 2'b00;
        case (state_q)
            S_IDLE: begin
                busy_o    = 1'b0;
                ready_vec = gnt_vec;
            end
            S_WR_ACT: csr_we_o = 1'b1;
            S_RD_ACT: csr_re_o = 1'b1;
            S_DONE: begin
                done_vec[idx_q] = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    assign req0_ready_o = ready_vec[0];
    assign req1_ready_o = ready_vec[1];
    assign req0_done_o  = done_vec[0];
    assign req1_done_o  = done_vec[1];
    assign req0_rdata_o = g_req[0].rdata_q;
    assign req1_rdata_o = g_req[1].rdata_q;
    assign csr_addr_o   = addr_q;
    assign csr_wdata_o  = wdata_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed testbench for csr_arbiter: a default-parameter instance plus a
// WR_HOLD=1/WR_GAP=1 instance for back-to-back write timing.
module tb_csr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-parameter instance signals
    logic       r0_valid, r0_we, r0_ready, r0_done;
    logic [6:0] r0_addr;
    logic [7:0] r0_wdata, r0_rdata;
    logic       r1_valid, r1_we, r1_ready, r1_done;
    logic [6:0] r1_addr;
    logic [7:0] r1_wdata, r1_rdata;
    logic [6:0] csr_addr;
    logic [7:0] csr_wdata, csr_rdata;
    logic       csr_we, csr_re, busy;

    // Fast instance signals
    logic       f0_valid, f0_we, f0_ready, f0_done;
    logic [6:0] f0_addr;
    logic [7:0] f0_wdata, f0_rdata;
    logic       f1_ready, f1_done;
    logic [7:0] f1_rdata;
    logic [6:0] fcsr_addr;
    logic [7:0] fcsr_wdata;
    logic       fcsr_we, fcsr_re, fbusy;

    int n_cmp = 0;
    int n_bad = 0;

    csr_arbiter u_dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(r0_valid), .req0_we_i(r0_we), .req0_addr_i(r0_addr),
        .req0_wdata_i(r0_wdata), .req0_ready_o(r0_ready), .req0_done_o(r0_done),
        .req0_rdata_o(r0_rdata),
        .req1_valid_i(r1_valid), .req1_we_i(r1_we), .req1_addr_i(r1_addr),
        .req1_wdata_i(r1_wdata), .req1_ready_o(r1_ready), .req1_done_o(r1_done),
        .req1_rdata_o(r1_rdata),
        .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata), .csr_we_o(csr_we),
        .csr_re_o(csr_re), .csr_rdata_i(csr_rdata), .busy_o(busy)
    );

    csr_arbiter #(.WR_HOLD(1), .WR_GAP(1)) u_dut_fast (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(f0_valid), .req0_we_i(f0_we), .req0_addr_i(f0_addr),
        .req0_wdata_i(f0_wdata), .req0_ready_o(f0_ready), .req0_done_o(f0_done),
        .req0_rdata_o(f0_rdata),
        .req1_valid_i(1'b0), .req1_we_i(1'b0), .req1_addr_i(7'h00),
        .req1_wdata_i(8'h00), .req1_ready_o(f1_ready), .req1_done_o(f1_done),
        .req1_rdata_o(f1_rdata),
        .csr_addr_o(fcsr_addr), .csr_wdata_o(fcsr_wdata), .csr_we_o(fcsr_we),
        .csr_re_o(fcsr_re), .csr_rdata_i(8'h00), .busy_o(fbusy)
    );

    // CSR slave model: read data becomes valid two cycles after csr_re_o rises.
    logic re_d1 = 1'b0;
    logic re_d2 = 1'b0;
    always @(posedge clk) begin
        re_d1 <= csr_re;
        re_d2 <= re_d1;
    end
    always_comb begin
        if (re_d2)
            csr_rdata = (csr_addr == 7'h03) ? 8'h3C : ({1'b0, csr_addr} ^ 8'h5A);
        else
            csr_rdata = 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Exclusivity checks every cycle on both instances.
    always @(negedge clk) begin
        check("excl_we_re", 32'(csr_we & csr_re), 32'd0);
        check("excl_done", 32'(r0_done & r1_done), 32'd0);
        check("fast_excl_we_re", 32'(fcsr_we & fcsr_re), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        f0_valid = 0; f0_we = 0; f0_addr = 0; f0_wdata = 0;
        tick();
        tick();

        // Reset state
        smp();
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(csr_we), 0);
        check("rst_re", 32'(csr_re), 0);
        check("rst_addr", 32'(csr_addr), 0);
        check("rst_wdata", 32'(csr_wdata), 0);
        check("rst_done", 32'({r1_done, r0_done}), 0);
        check("rst_rdata0", 32'(r0_rdata), 0);
        check("rst_rdata1", 32'(r1_rdata), 0);
        $display("txn reset: checked idle outputs");
        tick();
        rst = 1'b0;

        // Write from req0, first cycle after reset release
        r0_valid = 1; r0_we = 1; r0_addr = 7'h05; r0_wdata = 8'hA5;
        smp();
        check("wr_ready0", 32'(r0_ready), 1);
        check("wr_ready1", 32'(r1_ready), 0);
        check("wr_busy_T", 32'(busy), 0);
        tick();
        r0_valid = 0; r0_we = 0; r0_addr = 7'h7F; r0_wdata = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            smp();
            check($sformatf("wr_we_k%0d", k), 32'(csr_we), 32'(k <= 4));
            check($sformatf("wr_addr_k%0d", k), 32'(csr_addr), 32'h05);
            check($sformatf("wr_wdata_k%0d", k), 32'(csr_wdata), 32'hA5);
            check($sformatf("wr_done0_k%0d", k), 32'(r0_done), 32'(k == 9));
            check($sformatf("wr_busy_k%0d", k), 32'(busy), 32'(k <= 9));
            check($sformatf("wr_ready0_k%0d", k), 32'(r0_ready), 0);
            tick();
        end
        $display("txn write req0 addr=0x05 data=0xA5");

        // Read from req1 at address 0x03
        r1_valid = 1; r1_we = 0; r1_addr = 7'h03; r1_wdata = 8'h00;
        smp();
        check("rd_ready1", 32'(r1_ready), 1);
        check("rd_ready0", 32'(r0_ready), 0);
        tick();
        r1_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            smp();
            check($sformatf("rd_re_k%0d", k), 32'(csr_re), 32'(k <= 3));
            check($sformatf("rd_we_k%0d", k), 32'(csr_we), 0);
            check($sformatf("rd_done1_k%0d", k), 32'(r1_done), 32'(k == 4));
            check($sformatf("rd_done0_k%0d", k), 32'(r0_done), 0);
            check($sformatf("rd_rdata1_k%0d", k), 32'(r1_rdata), (k >= 4) ? 32'h3C : 32'h00);
            check($sformatf("rd_rdata0_k%0d", k), 32'(r0_rdata), 0);
            check($sformatf("rd_addr_k%0d", k), 32'(csr_addr), 32'h03);
            tick();
        end
        $display("txn read req1 addr=0x03 rdata=0x%0h", r1_rdata);

        // Round robin with both valid right after reset
        rst = 1;
        r0_valid = 1; r0_we = 1; r0_addr = 7'h11; r0_wdata = 8'h22;
        r1_valid = 1; r1_we = 1; r1_addr = 7'h33; r1_wdata = 8'h44;
        tick();
        rst = 0;
        for (int k = 0; k <= 20; k++) begin
            smp();
            if (k == 0) check("rr_rdata1_cleared", 32'(r1_rdata), 0);
            check($sformatf("rr_ready0_k%0d", k), 32'(r0_ready), 32'(k == 0 || k == 20));
            check($sformatf("rr_ready1_k%0d", k), 32'(r1_ready), 32'(k == 10));
            check($sformatf("rr_done0_k%0d", k), 32'(r0_done), 32'(k == 9));
            check($sformatf("rr_done1_k%0d", k), 32'(r1_done), 32'(k == 19));
            check($sformatf("rr_we_k%0d", k), 32'(csr_we),
                  32'((k >= 1 && k <= 4) || (k >= 11 && k <= 14)));
            check($sformatf("rr_addr_k%0d", k), 32'(csr_addr),
                  (k == 0) ? 32'h00 : ((k <= 10) ? 32'h11 : 32'h33));
            tick();
        end
        $display("txn round-robin req0 -> req1 -> req0");

        // Reset in the middle of the req0 write accepted above
        r0_valid = 0; r1_valid = 0;
        smp();
        check("ab_we_T1", 32'(csr_we), 1);
        check("ab_busy_T1", 32'(busy), 1);
        tick();
        rst = 1;
        smp();
        check("ab_we_T2", 32'(csr_we), 1);
        tick();
        rst = 0;
        smp();
        check("ab_we_T3", 32'(csr_we), 0);
        check("ab_busy_T3", 32'(busy), 0);
        check("ab_addr_T3", 32'(csr_addr), 0);
        check("ab_wdata_T3", 32'(csr_wdata), 0);
        check("ab_rdata1_T3", 32'(r1_rdata), 0);
        tick();
        for (int k = 4; k <= 14; k++) begin
            smp();
            check($sformatf("ab_done_k%0d", k), 32'({r1_done, r0_done}), 0);
            check($sformatf("ab_we_k%0d", k), 32'(csr_we), 0);
            check($sformatf("ab_busy_k%0d", k), 32'(busy), 0);
            tick();
        end
        $display("txn reset abort of req0 write");

        // req0 read with request inputs changing while busy
        r0_valid = 1; r0_we = 0; r0_addr = 7'h10; r0_wdata = 8'h99;
        smp();
        check("chg_ready0", 32'(r0_ready), 1);
        tick();
        r0_valid = 0; r0_we = 1; r0_addr = 7'h20; r0_wdata = 8'h77;
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) r0_valid = 1;
            if (k == 4) r0_valid = 0;
            smp();
            check($sformatf("chg_addr_k%0d", k), 32'(csr_addr), 32'h10);
            check($sformatf("chg_wdata_k%0d", k), 32'(csr_wdata), 32'h99);
            check($sformatf("chg_re_k%0d", k), 32'(csr_re), 32'(k <= 3));
            check($sformatf("chg_we_k%0d", k), 32'(csr_we), 0);
            check($sformatf("chg_ready0_k%0d", k), 32'(r0_ready), 0);
            check($sformatf("chg_done0_k%0d", k), 32'(r0_done), 32'(k == 4));
            check($sformatf("chg_rdata0_k%0d", k), 32'(r0_rdata), (k >= 4) ? 32'h4A : 32'h00);
            tick();
        end
        $display("txn read req0 addr=0x10 rdata=0x%0h with inputs changing", r0_rdata);

        // Back-to-back writes on the WR_HOLD=1 / WR_GAP=1 instance
        f0_valid = 1; f0_we = 1; f0_addr = 7'h01; f0_wdata = 8'h11;
        for (int k = 0; k <= 7; k++) begin
            if (k == 1) begin f0_addr = 7'h02; f0_wdata = 8'h22; end
            if (k == 5) f0_valid = 0;
            smp();
            check($sformatf("b2b_ready_k%0d", k), 32'(f0_ready), 32'(k == 0 || k == 4));
            check($sformatf("b2b_we_k%0d", k), 32'(fcsr_we), 32'(k == 1 || k == 5));
            check($sformatf("b2b_done_k%0d", k), 32'(f0_done), 32'(k == 3 || k == 7));
            check($sformatf("b2b_busy_k%0d", k), 32'(fbusy), 32'(k != 0 && k != 4));
            if (k >= 1)
                check($sformatf("b2b_addr_k%0d", k), 32'(fcsr_addr), (k <= 4) ? 32'h01 : 32'h02);
            tick();
        end
        $display("txn back-to-back writes req0 on fast instance");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_arbiter.md
CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 7, which is the CSR address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, which is the CSR data width.
REQ-003 The block SHALL have parameter WR_HOLD, default 4, which is the number of cycles csr_we_o stays high per write (legal range 1..15).
REQ-004 The block SHALL have parameter WR_GAP, default 4, which is the number of cycles after csr_we_o falls during which address and data are held (legal range 1..15).
REQ-005 The block SHALL have parameter RD_WAIT, default 3, which is the number of cycles csr_re_o stays high per read (legal range 3..15).
REQ-006 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit, the reset, which is synchronous and active-high.
REQ-008 For each requester n in {0,1}, the block SHALL have port reqn_valid_i, input, 1 bit, which signals that a request is pending.
REQ-009 For each requester n, the block SHALL have port reqn_we_i, input, 1 bit, where 1 = write and 0 = read.
REQ-010 For each requester n, the block SHALL have port reqn_addr_i, input, ADDR_WIDTH bits, the target address.
REQ-011 For each requester n, the block SHALL have port reqn_wdata_i, input, DATA_WIDTH bits, the write data.
REQ-012 For each requester n, the block SHALL have port reqn_ready_o, output, 1 bit, the accept strobe.
REQ-013 For each requester n, the block SHALL have port reqn_done_o, output, 1 bit, a one-cycle completion pulse.
REQ-014 For each requester n, the block SHALL have port reqn_rdata_o, output, DATA_WIDTH bits, the read result.
REQ-015 The block SHALL have port csr_addr_o, output, ADDR_WIDTH bits, the CSR address.
REQ-016 The block SHALL have port csr_wdata_o, output, DATA_WIDTH bits, the CSR write data.
REQ-017 The block SHALL have port csr_we_o, output, 1 bit, the level-type CSR write enable.
REQ-018 The block SHALL have port csr_re_o, output, 1 bit, the CSR read enable.
REQ-019 The block SHALL have port csr_rdata_i, input, DATA_WIDTH bits, the CSR read data.
REQ-020 The block SHALL have port busy_o, output, 1 bit, which is high whenever the state is not IDLE.

Function
REQ-021 The state machine SHALL have the states IDLE, WR_ACT, WR_GAP, RD_ACT and DONE, with a 4-bit down-counter for timing.
REQ-022 In IDLE, the block SHALL raise exactly one reqn_ready_o, combinationally, to the granted requester; all other cycles SHALL have both ready outputs at 0.
REQ-023 Grant SHALL be round-robin: with a single valid the grant goes to that requester, and with both valid the grant goes to the requester not served last.
REQ-024 A request SHALL be accepted at cycle T when reqn_valid_i && reqn_ready_o; on acceptance the block latches we, addr, wdata and the requester index.
REQ-025 For an accepted write, csr_we_o SHALL be 1 in cycles T+1..T+WR_HOLD (state WR_ACT), then 0 for WR_GAP cycles (state WR_GAP).
REQ-026 For an accepted write, reqn_done_o SHALL pulse at T+WR_HOLD+WR_GAP+1 (state DONE).
REQ-027 For an accepted read, csr_re_o SHALL be 1 in cycles T+1..T+RD_WAIT (state RD_ACT).
REQ-028 For an accepted read, csr_rdata_i SHALL be registered into reqn_rdata_o at the clock edge ending cycle T+RD_WAIT.
REQ-029 For an accepted read, reqn_done_o SHALL pulse at T+RD_WAIT+1.
REQ-030 csr_addr_o and csr_wdata_o SHALL be registered from the latched request, held constant from T+1 through DONE, and retained after DONE until the next acceptance.
REQ-031 DONE SHALL last one cycle and then return to IDLE, so a new acceptance is possible at the earliest one cycle after done.
REQ-032 reqn_rdata_o SHALL change only on completion of a read for requester n and hold otherwise; writes SHALL leave it unchanged.
REQ-033 The block SHALL never assert csr_we_o and csr_re_o in the same cycle, and SHALL never assert both done outputs in the same cycle.
REQ-034 While busy, changes on any reqn_* input SHALL have no effect on the transaction in flight.
REQ-035 A requester dropping valid before ready SHALL be legal, and nothing SHALL be issued for it.
REQ-036 No address range check SHALL be done; out-of-range data returned on csr_rdata_i SHALL be forwarded as-is.

Reset
REQ-037 While rst_i is high at a clock edge, the next state SHALL be IDLE.
REQ-038 Reset SHALL clear csr_addr_o, csr_wdata_o, csr_we_o, csr_re_o, both reqn_done_o and both reqn_rdata_o to 0, and the counter to 0.
REQ-039 Reset SHALL set the last-served requester to 1, so requester 0 wins the first tie.
REQ-040 When reset is asserted mid-transaction, the block SHALL abort it: csr_we_o/csr_re_o are 0 from the next cycle, no done pulse is issued, and the request is lost.
REQ-041 In the first cycle after reset is released, ready SHALL be available if any valid input is high.

Verification
REQ-042 A bench SHALL cover: req0 write addr=0x05 data=0xA5 accepted at T -> csr_we_o high for T+1..T+4, csr_addr_o=0x05 and csr_wdata_o=0xA5 through T+9, req0_done_o single pulse at T+9.
REQ-043 A bench SHALL cover: req1 read addr=0x03 with a model returning 0x3C two cycles after csr_re_o -> csr_re_o high for T+1..T+3, req1_done_o at T+4 with req1_rdata_o=0x3C, req0_rdata_o unchanged.
REQ-044 A bench SHALL cover: both valid in the first cycle after reset -> req0 granted first, req1 granted at the IDLE following req0's DONE, then req0 again if still valid.
REQ-045 A bench SHALL cover: rst_i pulsed at T+2 of a write -> csr_we_o 0 from T+3, no done pulse, all outputs at reset values, busy_o 0.
REQ-046 A bench SHALL cover: req0 changes addr/wdata/we while busy -> the CSR port keeps the latched values, and the checker flags any we&&re overlap or double done.
REQ-047 A bench SHALL cover: back-to-back req0 writes at WR_HOLD=1, WR_GAP=1 -> done at T+3, next acceptance at T+4.
